line_adc_sampler: RTL and testbench
===================================

# line_adc_sampler

Pixel-sampling stage directly downstream of the start-pulse/trigger qualifier. The qualifier raises `clock_to_ADC_req` once a frame start has been seen and a pixel trigger has arrived. From that point this block turns each rising edge of `AD_trig_signal` into one ADC convert clock. It captures the converted word after the ADC latency, emits it with a pixel index, and after the last pixel pulses `end_frame_o`. That pulse drives the qualifier's `reset_after_end_frame`.

## Interface
- `DATA_W`, 12: ADC output word width.
- `PIXELS`, 1024: pixels per line/frame; must be ≥ 2.
- `CLK_HI_CYC`, 4: `adc_clk_o` high time in `clk_200MHz_i` cycles; must be ≥ 1.
- `LAT_CYC`, 6: cycles from `adc_clk_o` falling to data capture; must be ≥ 1.
- `PIX_W`, $clog2(PIXELS): pixel index width.

- `clk_200MHz_i`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clock_to_ADC_req`  in  1  level from the qualifier; high means the frame is qualified.
- `AD_trig_signal`  in  1  pixel trigger, synchronous to `clk_200MHz_i`.
- `adc_data_i`  in  DATA_W  ADC parallel output.
- `adc_clk_o`  out  1  ADC convert clock, registered.
- `pix_data_o`  out  DATA_W  captured pixel word.
- `pix_index_o`  out  PIX_W  index of `pix_data_o`, 0..PIXELS-1.
- `pix_valid_o`  out  1  one-cycle qualifier for `pix_data_o` and `pix_index_o`.
- `end_frame_o`  out  1  one-cycle pulse after the last pixel; connects to `reset_after_end_frame`.
- `overrun_o`  out  1  sticky: a trigger edge arrived while a conversion was in progress.

## Operation
- Reset values: `adc_clk_o`, `pix_valid_o`, `end_frame_o` and `overrun_o` are 0; `pix_data_o` and `pix_index_o` are 0; state is IDLE; pixel counter is 0; `trig_d` is 0.
- Trigger edge: `trig_rise = AD_trig_signal & ~trig_d`, where `trig_d` is `AD_trig_signal` registered one cycle.
- State machine:
  - IDLE: `clock_to_ADC_req` = 1 → WAIT_TRIG; clear the pixel counter and `overrun_o`.
  - WAIT_TRIG: `trig_rise` → CLK_HI.
  - CLK_HI: `adc_clk_o` = 1 for CLK_HI_CYC cycles → CLK_LO.
  - CLK_LO: `adc_clk_o` = 0 for LAT_CYC cycles; on the last cycle, register `adc_data_i` → VALID.
  - VALID: `pix_valid_o` = 1 for one cycle; increment the counter. If the counter was PIXELS-1 → END, else → WAIT_TRIG.
  - END: `end_frame_o` = 1 for one cycle → WAIT_LOW.
  - WAIT_LOW: hold until `clock_to_ADC_req` = 0 → IDLE. This keeps a stale request level from re-arming the block.
- Pixel counter: width PIX_W. It never wraps within a frame, because END is taken at PIXELS-1. `pix_index_o` equals the counter value before the increment.
- Overrun:
  - A `trig_rise` in CLK_HI, CLK_LO or VALID sets `overrun_o` and is dropped; no extra conversion is queued.
  - A `trig_rise` in END or WAIT_LOW is ignored and does not set `overrun_o`.
  - `overrun_o` clears only on `reset` or on IDLE→WAIT_TRIG.
- Abort: if `clock_to_ADC_req` = 0 in any state other than IDLE or WAIT_LOW, go to IDLE on the next edge.
  - `adc_clk_o` goes low with the state change.
  - No `pix_valid_o` or `end_frame_o` is issued.
  - The counter clears on the next arm.
- Simultaneous `trig_rise` and `clock_to_ADC_req` falling in WAIT_TRIG: abort wins; no conversion.
- `reset` asserted mid-conversion: all outputs return to their reset values asynchronously.

## Timing
- Let E be the cycle in which `trig_rise` = 1 while in WAIT_TRIG.
- `adc_clk_o` is high in cycles E+1 .. E+CLK_HI_CYC and low from E+CLK_HI_CYC+1.
- `adc_data_i` is captured at the end of cycle E+CLK_HI_CYC+LAT_CYC.
- `pix_valid_o` is high in cycle E+CLK_HI_CYC+LAT_CYC+1 (E+11 with defaults).
- The block is back in WAIT_TRIG at E+CLK_HI_CYC+LAT_CYC+2. The minimum trigger spacing without overrun is CLK_HI_CYC+LAT_CYC+2 cycles (12 with defaults).
- `end_frame_o` is high in the cycle after the final `pix_valid_o`.
- `pix_data_o` and `pix_index_o` hold their last values until the next capture.

## Structure
- Shared package `line_adc_pkg`:
  - state enum (IDLE, WAIT_TRIG, CLK_HI, CLK_LO, VALID, END, WAIT_LOW);
  - default constants for DATA_W, PIXELS, CLK_HI_CYC, LAT_CYC.
- Sub-module `adc_strobe_gen`:
  - start input; outputs `adc_clk_o`, a capture strobe and a done strobe;
  - holds the CLK_HI/CLK_LO down-counter and has its own abort input.
- Top level holds the FSM, pixel counter, edge detector, overrun flag and output registers.

## Test plan
- Nominal frame (PIXELS=4, default timing): raise `clock_to_ADC_req`; 4 trigger edges 20 cycles apart; `adc_data_i` = 0x100+index. Expect:
  - 4 `pix_valid_o` pulses, each 11 cycles after its edge;
  - `pix_index_o` 0..3 with data 0x100..0x103;
  - `end_frame_o` 1 cycle after the 4th valid.
- Overrun: second trigger edge 5 cycles after the first. Expect `overrun_o` = 1 from then on, a single conversion only, and index not advanced twice.
- Stale request: hold `clock_to_ADC_req` high for 3 cycles after `end_frame_o` and apply a trigger edge in that window. Expect no conversion; the block re-arms only after the request goes low then high.
- Abort: drop `clock_to_ADC_req` 2 cycles into CLK_HI. Expect `adc_clk_o` = 0 next cycle, no valid, and state IDLE. Re-arm, then expect the next pixel to use index 0.
- Async reset mid-CLK_LO: assert `reset` low between clock edges. Expect all outputs 0 immediately and `overrun_o` cleared.
- Trigger held high 50 cycles: expect exactly one conversion, with edge detection only.

Source files
------------

// File: rtl/line_adc_pkg.sv
// Shared types and default constants for the line ADC sampling stage.
package line_adc_pkg;

    localparam int DATA_W_DEF     = 12;
    localparam int PIXELS_DEF     = 1024;
    localparam int CLK_HI_CYC_DEF = 4;
    localparam int LAT_CYC_DEF    = 6;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TRIG,
        CLK_HI,
        CLK_LO,
        VALID,
        END,
        WAIT_LOW
    } state_e;

    function automatic int cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/adc_strobe_gen.sv
// ADC convert clock generator: high phase, then latency phase ending in a capture strobe.
module adc_strobe_gen
    import line_adc_pkg::*;
#(
    parameter int CLK_HI_CYC = CLK_HI_CYC_DEF,
    parameter int LAT_CYC    = LAT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic abort_i,
    output logic adc_clk_o,
    output logic hi_end_o,
    output logic capture_o,
    output logic done_o
);

    localparam int CNT_W = cnt_w(CLK_HI_CYC, LAT_CYC);
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(CLK_HI_CYC - 1);
    localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(LAT_CYC - 1);

    logic             hi_q, hi_d;
    logic             lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        if (abort_i) begin
            hi_d  = 1'b0;
            lo_d  = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            hi_d  = 1'b1;
            lo_d  = 1'b0;
            cnt_d = HI_LOAD;
        end else if (hi_q) begin
            if (cnt_q == '0) begin
                hi_d  = 1'b0;
                lo_d  = 1'b1;
                cnt_d = LO_LOAD;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (lo_q) begin
            if (cnt_q == '0) begin
                lo_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    // The flop itself is the convert clock, so it is glitch-free.
    assign adc_clk_o = hi_q;
    assign hi_end_o  = hi_q & (cnt_q == '0);
    assign capture_o = lo_q & (cnt_q == '0);
    assign done_o    = capture_o;

endmodule

// File: rtl/line_adc_sampler.sv
// Turns qualified pixel-trigger edges into ADC conversions and emits indexed pixel words.
module line_adc_sampler
    import line_adc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PIXELS     = PIXELS_DEF,
    parameter int CLK_HI_CYC = CLK_HI_CYC_DEF,
    parameter int LAT_CYC    = LAT_CYC_DEF,
    parameter int PIX_W      = $clog2(PIXELS)
) (
    input  logic              clk_200MHz_i,
    input  logic              reset,
    input  logic              clock_to_ADC_req,
    input  logic              AD_trig_signal,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              adc_clk_o,
    output logic [DATA_W-1:0] pix_data_o,
    output logic [PIX_W-1:0]  pix_index_o,
    output logic              pix_valid_o,
    output logic              end_frame_o,
    output logic              overrun_o
);

    localparam logic [PIX_W-1:0] LAST = PIX_W'(PIXELS - 1);

    state_e            state_q, state_d;
    logic [PIX_W-1:0]  cnt_q, cnt_d;
    logic [PIX_W-1:0]  index_q, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovr_q, ovr_d;
    logic              valid_q, valid_d;
    logic              end_q, end_d;
    logic              trig_d_q;
    logic              trig_rise;
    logic              start, abort;
    logic              hi_end, capture, done;

    assign trig_rise = AD_trig_signal & ~trig_d_q;

    adc_strobe_gen #(
        .CLK_HI_CYC (CLK_HI_CYC),
        .LAT_CYC    (LAT_CYC)
    ) u_strobe (
        .clk_i     (clk_200MHz_i),
        .rst_ni    (reset),
        .start_i   (start),
        .abort_i   (abort),
        .adc_clk_o (adc_clk_o),
        .hi_end_o  (hi_end),
        .capture_o (capture),
        .done_o    (done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        index_d = index_q;
        data_d  = data_q;
        ovr_d   = ovr_q;
        start   = 1'b0;
        abort   = ~clock_to_ADC_req
                & (state_q != IDLE)
                & (state_q != WAIT_LOW);

        if (trig_rise && (state_q == CLK_HI || state_q == CLK_LO
                          || state_q == VALID))
            ovr_d = 1'b1;

        case (state_q)
            IDLE: if (clock_to_ADC_req) begin
                state_d = WAIT_TRIG;
                cnt_d   = '0;
                ovr_d   = 1'b0;
            end
            WAIT_TRIG: if (trig_rise && clock_to_ADC_req) begin
                state_d = CLK_HI;
                start   = 1'b1;
            end
            CLK_HI: if (hi_end) state_d = CLK_LO;
            CLK_LO: if (done && clock_to_ADC_req) begin
                state_d = VALID;
                data_d  = adc_data_i;
                index_d = cnt_q;
            end
            VALID: if (cnt_q == LAST) begin
                state_d = END;
            end else begin
                state_d = WAIT_TRIG;
                cnt_d   = cnt_q + PIX_W'(1);
            end
            END:      state_d = WAIT_LOW;
            WAIT_LOW: if (!clock_to_ADC_req) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Dropping the request mid-line abandons the frame without any pulse.
        if (abort) state_d = IDLE;

        valid_d = (state_d == VALID);
        end_d   = (state_d == END);
    end

    always_ff @(posedge clk_200MHz_i or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            index_q  <= '0;
            data_q   <= '0;
            ovr_q    <= 1'b0;
            valid_q  <= 1'b0;
            end_q    <= 1'b0;
            trig_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            index_q  <= index_d;
            data_q   <= data_d;
            ovr_q    <= ovr_d;
            valid_q  <= valid_d;
            end_q    <= end_d;
            trig_d_q <= AD_trig_signal;
        end
    end

    assign pix_data_o  = data_q;
    assign pix_index_o = index_q;
    assign pix_valid_o = valid_q;
    assign end_frame_o = end_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_line_adc_sampler.sv
// Scenario bench for line_adc_sampler with a timing-rule reference model.
module tb_line_adc_sampler;

    localparam int DW   = 12;
    localparam int NPIX = 4;
    localparam int HI   = 4;
    localparam int LAT  = 6;
    localparam int PW   = 2;
    localparam int VLAT = HI + LAT + 1;
    localparam int SPAN = HI + LAT + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req = 1'b0;
    logic          trig = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_clk_o;
    logic [DW-1:0] pix_data_o;
    logic [PW-1:0] pix_index_o;
    logic          pix_valid_o;
    logic          end_frame_o;
    logic          overrun_o;

    line_adc_sampler #(
        .DATA_W     (DW),
        .PIXELS     (NPIX),
        .CLK_HI_CYC (HI),
        .LAT_CYC    (LAT)
    ) dut (
        .clk_200MHz_i     (clk),
        .reset            (rst_n),
        .clock_to_ADC_req (req),
        .AD_trig_signal   (trig),
        .adc_data_i       (adc_data),
        .adc_clk_o        (adc_clk_o),
        .pix_data_o       (pix_data_o),
        .pix_index_o      (pix_index_o),
        .pix_valid_o      (pix_valid_o),
        .end_frame_o      (end_frame_o),
        .overrun_o        (overrun_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int idx;
        int data;
    } ev_t;

    int  hist[int];
    ev_t obs_v[$];
    ev_t exp_v[$];
    int  obs_end[$];
    int  exp_end[$];
    int  hi_cnt = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    int  m_mode = 0;
    int  m_idx = 0;
    int  m_busy = 0;
    int  m_arm = 0;
    bit  m_ovr = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        if (pix_valid_o) begin
            e.c    = cyc;
            e.idx  = int'(pix_index_o);
            e.data = int'(pix_data_o);
            obs_v.push_back(e);
        end
        if (end_frame_o) obs_end.push_back(cyc);
        if (adc_clk_o) hi_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            adc_data = DW'($urandom);
            hist[cyc] = int'(adc_data);
        end
    endtask

    // Model: an edge at t while armed and idle yields a pixel at t+VLAT
    // carrying the word driven at t+VLAT-1; busy edges only flag overrun.
    task automatic model_trig(input int t);
        ev_t e;
        if (m_mode == 1 && t >= m_arm && t >= m_busy) begin
            e.c    = t + VLAT;
            e.idx  = m_idx;
            e.data = t + VLAT - 1;
            exp_v.push_back(e);
            m_busy = t + SPAN;
            m_idx++;
            if (m_idx == NPIX) begin
                exp_end.push_back(t + SPAN);
                m_mode = 2;
            end
        end else if (m_mode != 0 && t < m_busy) begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic set_req(input bit v);
        ev_t keep[$];
        int  keep_e[$];
        req = v;
        if (v && m_mode == 0) begin
            m_mode = 1;
            m_arm  = cyc + 1;
            m_busy = cyc + 1;
            m_idx  = 0;
            m_ovr  = 1'b0;
        end else if (!v) begin
            m_mode = 0;
            foreach (exp_v[i]) if (exp_v[i].c <= cyc) keep.push_back(exp_v[i]);
            foreach (exp_end[i]) if (exp_end[i] <= cyc) keep_e.push_back(exp_end[i]);
            exp_v   = keep;
            exp_end = keep_e;
        end
    endtask

    task automatic pulse(input int w);
        trig = 1'b1;
        model_trig(cyc);
        step(w);
        trig = 1'b0;
    endtask

    task automatic fresh_arm();
        set_req(1'b0);
        step(3);
        obs_v.delete();
        exp_v.delete();
        obs_end.delete();
        exp_end.delete();
        hi_cnt = 0;
        set_req(1'b1);
        step(3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_checks++;
        if ({adc_clk_o, pix_valid_o, end_frame_o, overrun_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000",
                     {adc_clk_o, pix_valid_o, end_frame_o, overrun_o});
        end
        n_checks++;
        if ({pix_data_o, pix_index_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data %h idx %0d want 0 0",
                     pix_data_o, pix_index_o);
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_nominal();
        int w;
        fresh_arm();
        for (int p = 0; p < NPIX; p++) begin
            w = $urandom_range(1, 3);
            pulse(w);
            step(HI - w);
            n_checks++;
            if (adc_clk_o !== 1'b1) begin
                n_fail++;
                $display("FAIL nominal_clk_hi%0d: got %b want 1", p, adc_clk_o);
            end
            step(1);
            n_checks++;
            if (adc_clk_o !== 1'b0) begin
                n_fail++;
                $display("FAIL nominal_clk_lo%0d: got %b want 0", p, adc_clk_o);
            end
            step(20 - HI - 1);
        end
        step(5);
        n_checks++;
        if (obs_v.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL nominal_count: got %0d want %0d", obs_v.size(), exp_v.size());
        end else begin
            for (int i = 0; i < exp_v.size(); i++) begin
                n_checks++;
                if (obs_v[i].c != exp_v[i].c || obs_v[i].idx != exp_v[i].idx
                    || obs_v[i].data != hist[exp_v[i].data]) begin
                    n_fail++;
                    $display("FAIL nominal_pix%0d: got cyc %0d idx %0d data %h want cyc %0d idx %0d data %h",
                             i, obs_v[i].c, obs_v[i].idx, obs_v[i].data,
                             exp_v[i].c, exp_v[i].idx, hist[exp_v[i].data]);
                end
            end
        end
        n_checks++;
        if (obs_end.size() != exp_end.size()
            || (exp_end.size() > 0 && obs_end[0] != exp_end[0])) begin
            n_fail++;
            $display("FAIL nominal_end: got %0d pulses (first %0d) want %0d (at %0d)",
                     obs_end.size(), obs_end.size() ? obs_end[0] : -1,
                     exp_end.size(), exp_end.size() ? exp_end[0] : -1);
        end
        n_checks++;
        if (hi_cnt != HI * NPIX) begin
            n_fail++;
            $display("FAIL nominal_clk_cycles: got %0d want %0d", hi_cnt, HI * NPIX);
        end
        n_checks++;
        if (overrun_o !== m_ovr) begin
            n_fail++;
            $display("FAIL nominal_overrun: got %b want %b", overrun_o, m_ovr);
        end
    endtask

    task automatic test_overrun();
        fresh_arm();
        pulse(2);
        step(3);
        pulse(1);
        n_checks++;
        if (overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b want 1", overrun_o);
        end
        step(20);
        pulse(1);
        step(15);
        n_checks++;
        if (obs_v.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d want %0d", obs_v.size(), exp_v.size());
        end else begin
            for (int i = 0; i < exp_v.size(); i++) begin
                n_checks++;
                if (obs_v[i].c != exp_v[i].c || obs_v[i].idx != exp_v[i].idx
                    || obs_v[i].data != hist[exp_v[i].data]) begin
                    n_fail++;
                    $display("FAIL overrun_pix%0d: got cyc %0d idx %0d want cyc %0d idx %0d",
                             i, obs_v[i].c, obs_v[i].idx, exp_v[i].c, exp_v[i].idx);
                end
            end
        end
        n_checks++;
        if (overrun_o !== m_ovr) begin
            n_fail++;
            $display("FAIL overrun_sticky: got %b want %b", overrun_o, m_ovr);
        end
    endtask

    task automatic test_stale_request();
        int w;
        fresh_arm();
        for (int p = 0; p < NPIX - 1; p++) begin
            w = $urandom_range(1, 3);
            pulse(w);
            step(14 - w);
        end
        pulse(1);
        step(SPAN);
        pulse(1);
        step(1);
        set_req(1'b0);
        step(20);
        set_req(1'b1);
        step(2);
        pulse(1);
        step(15);
        n_checks++;
        if (obs_v.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL stale_count: got %0d want %0d", obs_v.size(), exp_v.size());
        end else begin
            for (int i = 0; i < exp_v.size(); i++) begin
                n_checks++;
                if (obs_v[i].c != exp_v[i].c || obs_v[i].idx != exp_v[i].idx
                    || obs_v[i].data != hist[exp_v[i].data]) begin
                    n_fail++;
                    $display("FAIL stale_pix%0d: got cyc %0d idx %0d want cyc %0d idx %0d",
                             i, obs_v[i].c, obs_v[i].idx, exp_v[i].c, exp_v[i].idx);
                end
            end
        end
        n_checks++;
        if (obs_end.size() != exp_end.size()
            || (exp_end.size() > 0 && obs_end[0] != exp_end[0])) begin
            n_fail++;
            $display("FAIL stale_end: got %0d pulses want %0d",
                     obs_end.size(), exp_end.size());
        end
        n_checks++;
        if (overrun_o !== m_ovr) begin
            n_fail++;
            $display("FAIL stale_overrun: got %b want %b", overrun_o, m_ovr);
        end
    endtask

    task automatic test_abort();
        fresh_arm();
        pulse(1);
        step(15);
        pulse(1);
        step(1);
        n_checks++;
        if (adc_clk_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_clk_before: got %b want 1", adc_clk_o);
        end
        set_req(1'b0);
        step(1);
        n_checks++;
        if (adc_clk_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clk_after: got %b want 0", adc_clk_o);
        end
        step(15);
        set_req(1'b1);
        step(2);
        pulse(1);
        step(15);
        n_checks++;
        if (obs_v.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL abort_count: got %0d want %0d", obs_v.size(), exp_v.size());
        end else begin
            for (int i = 0; i < exp_v.size(); i++) begin
                n_checks++;
                if (obs_v[i].c != exp_v[i].c || obs_v[i].idx != exp_v[i].idx
                    || obs_v[i].data != hist[exp_v[i].data]) begin
                    n_fail++;
                    $display("FAIL abort_pix%0d: got cyc %0d idx %0d want cyc %0d idx %0d",
                             i, obs_v[i].c, obs_v[i].idx, exp_v[i].c, exp_v[i].idx);
                end
            end
        end
        n_checks++;
        if (obs_end.size() != 0) begin
            n_fail++;
            $display("FAIL abort_end: got %0d pulses want 0", obs_end.size());
        end
    endtask

    task automatic test_async_reset();
        fresh_arm();
        pulse(1);
        step(2);
        pulse(1);
        step(3);
        n_checks++;
        if (overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre_overrun: got %b want 1", overrun_o);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({adc_clk_o, pix_valid_o, end_frame_o, overrun_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL areset_flags: got %b want 0000",
                     {adc_clk_o, pix_valid_o, end_frame_o, overrun_o});
        end
        n_checks++;
        if ({pix_data_o, pix_index_o} !== '0) begin
            n_fail++;
            $display("FAIL areset_data: got data %h idx %0d want 0 0",
                     pix_data_o, pix_index_o);
        end
        set_req(1'b0);
        m_ovr = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(15);
        n_checks++;
        if (obs_v.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL areset_count: got %0d want %0d", obs_v.size(), exp_v.size());
        end
        n_checks++;
        if (overrun_o !== m_ovr) begin
            n_fail++;
            $display("FAIL areset_overrun: got %b want %b", overrun_o, m_ovr);
        end
    endtask

    task automatic test_held_trigger();
        fresh_arm();
        trig = 1'b1;
        model_trig(cyc);
        step(50);
        trig = 1'b0;
        step(15);
        n_checks++;
        if (obs_v.size() != exp_v.size()) begin
            n_fail++;
            $display("FAIL held_count: got %0d want %0d", obs_v.size(), exp_v.size());
        end else begin
            for (int i = 0; i < exp_v.size(); i++) begin
                n_checks++;
                if (obs_v[i].c != exp_v[i].c || obs_v[i].idx != exp_v[i].idx
                    || obs_v[i].data != hist[exp_v[i].data]) begin
                    n_fail++;
                    $display("FAIL held_pix%0d: got cyc %0d idx %0d data %h want cyc %0d idx %0d data %h",
                             i, obs_v[i].c, obs_v[i].idx, obs_v[i].data,
                             exp_v[i].c, exp_v[i].idx, hist[exp_v[i].data]);
                end
            end
        end
        n_checks++;
        if (hi_cnt != HI) begin
            n_fail++;
            $display("FAIL held_clk_cycles: got %0d want %0d", hi_cnt, HI);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_nominal();
        test_overrun();
        test_stale_request();
        test_abort();
        test_async_reset();
        test_held_trigger();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
